// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  pc_redirect_ctrl : fetch PC owner; sequences EX redirects, load-use stalls
//                     and wrong-path squashing for the 5-stage pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        pc_hold,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        addr_err,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t      state;
  logic [2:0]  cnt;

  logic        redirect;
  logic        misaligned;
  logic [31:0] pc_seq;
  logic [31:0] redirect_pc;
  logic [15:0] redirect_cnt_next;

  assign redirect          = br_valid & br_taken;
  assign misaligned        = |br_target[1:0];
  assign pc_seq            = pc + 32'd4;
  assign redirect_pc       = misaligned ? EXC_VECTOR : br_target;
  assign redirect_cnt_next = (redirect_cnt == 16'hFFFF) ? redirect_cnt
                                                        : redirect_cnt + 16'd1;

  // A taken redirect squashes the stalled younger instruction, so it wins.
  assign pc_hold = stall_in & (state == ST_RUN) & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      cnt          <= 3'd0;
      pc           <= RESET_PC;
      flush_ifid   <= 1'b0;
      flush_idex   <= 1'b0;
      addr_err     <= 1'b0;
      redirect_cnt <= 16'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            pc           <= redirect_pc;
            flush_ifid   <= 1'b1;
            flush_idex   <= 1'b1;
            cnt          <= FLUSH_INIT;
            redirect_cnt <= redirect_cnt_next;
            if (misaligned) begin
              addr_err <= 1'b1;
            end
            state <= MULTI_FLUSH ? ST_FLUSH : ST_RUN;
          end else if (stall_in) begin
            flush_ifid <= 1'b0;
            flush_idex <= 1'b1;
          end else begin
            pc         <= pc_seq;
            flush_ifid <= 1'b0;
            flush_idex <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // Everything arriving now is wrong-path; keep fetching sequentially.
          pc         <= pc_seq;
          flush_ifid <= 1'b1;
          flush_idex <= 1'b1;
          cnt        <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_pc_redirect_ctrl : scoreboard bench for pc_redirect_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall_in, br_valid, br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        pc_hold, flush_ifid, flush_idex, addr_err;
  logic [15:0] redirect_cnt;

  logic        stall1, br1_valid, br1_taken;
  logic [31:0] br1_target;
  logic [31:0] pc1;
  logic        pc_hold1, flush_ifid1, flush_idex1, addr_err1;
  logic [15:0] redirect_cnt1;

  pc_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .br_valid(br_valid),
    .br_taken(br_taken), .br_target(br_target), .pc(pc), .pc_hold(pc_hold),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .addr_err(addr_err),
    .redirect_cnt(redirect_cnt)
  );

  // Single-bubble variant: one redirect per cycle keeps the saturation run short.
  pc_redirect_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall1), .br_valid(br1_valid),
    .br_taken(br1_taken), .br_target(br1_target), .pc(pc1), .pc_hold(pc_hold1),
    .flush_ifid(flush_ifid1), .flush_idex(flush_idex1), .addr_err(addr_err1),
    .redirect_cnt(redirect_cnt1)
  );

  typedef struct {
    logic        hold;
    logic [31:0] pc;
    logic        fi;
    logic        fd;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the expected pc_hold and post-edge state.
  task automatic cyc(input logic v, input logic t, input logic [31:0] tg, input logic st,
                     input logic eh, input logic [31:0] ep, input logic efi,
                     input logic efd, input logic eerr, input logic [15:0] ecnt);
    exp_t e;
    br_valid  = v;
    br_taken  = t;
    br_target = tg;
    stall_in  = st;
    e.hold = eh; e.pc = ep; e.fi = efi; e.fd = efd; e.err = eerr; e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    int   idx;
    idx = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        idx++;
        chk($sformatf("pc_hold[%0d]", idx), {63'd0, pc_hold}, {63'd0, e.hold});
        @(posedge clk);
        #2;
        chk($sformatf("pc[%0d]", idx), {32'd0, pc}, {32'd0, e.pc});
        chk($sformatf("flush_ifid[%0d]", idx), {63'd0, flush_ifid}, {63'd0, e.fi});
        chk($sformatf("flush_idex[%0d]", idx), {63'd0, flush_idex}, {63'd0, e.fd});
        chk($sformatf("addr_err[%0d]", idx), {63'd0, addr_err}, {63'd0, e.err});
        chk($sformatf("redirect_cnt[%0d]", idx), {48'd0, redirect_cnt}, {48'd0, e.cnt});
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    stall_in = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    stall1 = 1'b0; br1_valid = 1'b0; br1_taken = 1'b0; br1_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", {32'd0, pc}, 64'h0);
    chk("reset_flush", {62'd0, flush_ifid, flush_idex}, 64'h0);
    chk("reset_err_cnt", {47'd0, addr_err, redirect_cnt}, 64'h0);
    rst_n = 1'b1;

    // free run
    cyc(0, 0, 32'h0, 0,  0, 32'h04, 0, 0, 0, 16'd0);
    cyc(0, 0, 32'h0, 0,  0, 32'h08, 0, 0, 0, 16'd0);
    cyc(0, 0, 32'h0, 0,  0, 32'h0C, 0, 0, 0, 16'd0);
    cyc(0, 0, 32'h0, 0,  0, 32'h10, 0, 0, 0, 16'd0);
    // taken redirect at 0x10, two flush cycles
    cyc(1, 1, 32'h40, 0, 0, 32'h40, 1, 1, 0, 16'd1);
    cyc(0, 0, 32'h0, 0,  0, 32'h44, 1, 1, 0, 16'd1);
    cyc(0, 0, 32'h0, 0,  0, 32'h48, 0, 0, 0, 16'd1);
    // steer to pc=0x20 in RUN
    cyc(1, 1, 32'h18, 0, 0, 32'h18, 1, 1, 0, 16'd2);
    cyc(0, 0, 32'h0, 0,  0, 32'h1C, 1, 1, 0, 16'd2);
    cyc(0, 0, 32'h0, 0,  0, 32'h20, 0, 0, 0, 16'd2);
    // load-use stall for 3 cycles
    cyc(0, 0, 32'h0, 1,  1, 32'h20, 0, 1, 0, 16'd2);
    cyc(0, 0, 32'h0, 1,  1, 32'h20, 0, 1, 0, 16'd2);
    cyc(0, 0, 32'h0, 1,  1, 32'h20, 0, 1, 0, 16'd2);
    cyc(0, 0, 32'h0, 0,  0, 32'h24, 0, 0, 0, 16'd2);
    // taken with stall; second branch in FLUSH ignored
    cyc(1, 1, 32'h100, 1, 0, 32'h100, 1, 1, 0, 16'd3);
    cyc(1, 1, 32'h300, 1, 0, 32'h104, 1, 1, 0, 16'd3);
    cyc(0, 0, 32'h0, 0,   0, 32'h108, 0, 0, 0, 16'd3);
    // not-taken branch: sequential, then stall
    cyc(1, 0, 32'h500, 0, 0, 32'h10C, 0, 0, 0, 16'd3);
    cyc(1, 0, 32'h500, 1, 1, 32'h10C, 0, 1, 0, 16'd3);
    // misaligned target
    cyc(1, 1, 32'h103, 0, 0, 32'h180, 1, 1, 1, 16'd4);
    cyc(0, 0, 32'h0, 0,   0, 32'h184, 1, 1, 1, 16'd4);
    cyc(0, 0, 32'h0, 0,   0, 32'h188, 0, 0, 1, 16'd4);
    cyc(1, 1, 32'h40, 0,  0, 32'h40, 1, 1, 1, 16'd5);

    // asynchronous reset while in FLUSH
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", {32'd0, pc}, 64'h0);
    chk("async_flush", {62'd0, flush_ifid, flush_idex}, 64'h0);
    chk("async_err_cnt", {47'd0, addr_err, redirect_cnt}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // wrap through 0xFFFF_FFFC
    cyc(1, 1, 32'hFFFF_FFF4, 0, 0, 32'hFFFF_FFF4, 1, 1, 0, 16'd1);
    cyc(0, 0, 32'h0, 0,         0, 32'hFFFF_FFF8, 1, 1, 0, 16'd1);
    cyc(0, 0, 32'h0, 0,         0, 32'hFFFF_FFFC, 0, 0, 0, 16'd1);
    cyc(0, 0, 32'h0, 0,         0, 32'h0000_0000, 0, 0, 0, 16'd1);
    // low-bit misalignment on bit 1 only
    cyc(1, 1, 32'h2, 0, 0, 32'h180, 1, 1, 1, 16'd2);
    cyc(0, 0, 32'h0, 0, 0, 32'h184, 1, 1, 1, 16'd2);
    cyc(0, 0, 32'h0, 0, 0, 32'h188, 0, 0, 1, 16'd2);
    br_valid = 1'b0; br_taken = 1'b0; stall_in = 1'b0;

    // redirect counter saturation on the single-bubble instance
    br1_valid = 1'b1; br1_taken = 1'b1; br1_target = 32'h200;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_cnt_fffe", {48'd0, redirect_cnt1}, 64'hFFFE);
    chk("sat_flush1", {62'd0, flush_ifid1, flush_idex1}, 64'h3);
    @(posedge clk);
    #1;
    chk("sat_cnt_ffff", {48'd0, redirect_cnt1}, 64'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_cnt_hold", {48'd0, redirect_cnt1}, 64'hFFFF);
    br1_valid = 1'b0; br1_taken = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_flush1_off", {62'd0, flush_ifid1, flush_idex1}, 64'h0);
    chk("sat_pc1", {32'd0, pc1}, 64'h204);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #5;
    if (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
